hsv2rgb: RTL and testbench

- Pipelined HSV-to-RGB converter; the inverse of the RGB-to-HSV stage in the colour pipeline.
- Accepts one packed HSV word per enabled cycle and produces the packed RGB word 3 enabled cycles later.
- Uses the same word packing as the upstream converter so the two blocks chain back-to-back for round-trip checks and overlay generation.

---
 rtl/hsv2rgb.sv | 182 ++++++++++++++++++
 tb/tb_hsv2rgb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hsv2rgb.sv
// hsv2rgb: three-stage pipelined HSV-to-RGB converter.
//
// Word packing matches the upstream RGB-to-HSV stage so the two can be
// chained directly.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high (wins over clk_en)
//   clk_en     pipeline advance enable; all registers hold when 0
//   in_valid   HSV carries a sample this cycle
//   HSV[31:0]  [31:24] h (2-degree units), [23:16] s, [15:8] v, [7:0] ignored
//   out_valid  RGB holds a converted sample
//   RGB[31:0]  [31:24] B, [23:16] G, [15:8] R, [7:0] zero
//
// Build option
//   HSV2RGB_ROUND_EN  when defined, every 8x8 product is rounded half-up
//                     before the >>8 instead of truncated. Latency and
//                     interface are unchanged.
//
// Pipeline
//   S1: hue wrap, region/fraction decode, s/v capture
//   S2: p, s*frac, s*(1-frac) products
//   S3: q, t products, region mux, registered output

module hsv2rgb #(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        in_valid,
  input  logic [31:0] HSV,
  output logic        out_valid,
  output logic [31:0] RGB
);

  localparam int unused_latency = LATENCY;

  logic unused_low_bits;
  assign unused_low_bits = ^HSV[7:0];

  // (a*b)>>8 with optional round-half-up; result always fits in 8 bits
  // for 8-bit operands, the clamp only guards the rounded form.
  function automatic logic [7:0] scale(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'(a) * 16'(b);
`ifdef HSV2RGB_ROUND_EN
    begin
      logic [16:0] sum;
      sum = {1'b0, prod} + 17'd128;
      scale = (sum > 17'd65535) ? 8'hFF : 8'(sum >> 8);
    end
`else
    scale = 8'(prod >> 8);
`endif
  endfunction

  // ---------------- S1 combinational ----------------
  logic [7:0] h_in;
  logic [7:0] h_wrap;
  logic [2:0] region_c;
  logic [7:0] base_c;
  logic [7:0] rem_c;
  logic [7:0] frac_c;

  assign h_in   = HSV[31:24];
  assign h_wrap = (h_in >= 8'd180) ? (h_in - 8'd180) : h_in;

  // Compare ladder instead of a divide by 30.
  always_comb begin
    region_c = 3'd0;
    base_c   = 8'd0;
    if (h_wrap >= 8'd150) begin
      region_c = 3'd5;
      base_c   = 8'd150;
    end else if (h_wrap >= 8'd120) begin
      region_c = 3'd4;
      base_c   = 8'd120;
    end else if (h_wrap >= 8'd90) begin
      region_c = 3'd3;
      base_c   = 8'd90;
    end else if (h_wrap >= 8'd60) begin
      region_c = 3'd2;
      base_c   = 8'd60;
    end else if (h_wrap >= 8'd30) begin
      region_c = 3'd1;
      base_c   = 8'd30;
    end
  end

  assign rem_c  = h_wrap - base_c;
  // rem*17/2 maps 0..29 onto 0..246, a close stand-in for rem*255/30.
  assign frac_c = 8'((13'(rem_c) * 13'd17) >> 1);

  // ---------------- stage registers ----------------
  logic       s1_valid;
  logic [2:0] s1_region;
  logic [7:0] s1_frac;
  logic [7:0] s1_s;
  logic [7:0] s1_v;
  logic       s1_szero;

  logic       s2_valid;
  logic [2:0] s2_region;
  logic [7:0] s2_v;
  logic       s2_szero;
  logic [7:0] s2_p;
  logic [7:0] s2_sf;
  logic [7:0] s2_sg;

  // ---------------- S3 combinational ----------------
  logic [7:0] q_c;
  logic [7:0] t_c;
  logic [7:0] r_c;
  logic [7:0] g_c;
  logic [7:0] b_c;

  assign q_c = scale(s2_v, 8'd255 - s2_sf);
  assign t_c = scale(s2_v, 8'd255 - s2_sg);

  always_comb begin
    r_c = s2_v;
    g_c = s2_p;
    b_c = q_c;
    case (s2_region)
      3'd0: begin r_c = s2_v; g_c = t_c;  b_c = s2_p; end
      3'd1: begin r_c = q_c;  g_c = s2_v; b_c = s2_p; end
      3'd2: begin r_c = s2_p; g_c = s2_v; b_c = t_c;  end
      3'd3: begin r_c = s2_p; g_c = q_c;  b_c = s2_v; end
      3'd4: begin r_c = t_c;  g_c = s2_p; b_c = s2_v; end
      default: begin r_c = s2_v; g_c = s2_p; b_c = q_c; end
    endcase
    if (s2_szero) begin
      r_c = s2_v;
      g_c = s2_v;
      b_c = s2_v;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_region <= 3'd0;
      s1_frac   <= 8'd0;
      s1_s      <= 8'd0;
      s1_v      <= 8'd0;
      s1_szero  <= 1'b0;
      s2_valid  <= 1'b0;
      s2_region <= 3'd0;
      s2_v      <= 8'd0;
      s2_szero  <= 1'b0;
      s2_p      <= 8'd0;
      s2_sf     <= 8'd0;
      s2_sg     <= 8'd0;
      out_valid <= 1'b0;
      RGB       <= 32'd0;
    end else if (clk_en) begin
      s1_valid  <= in_valid;
      s1_region <= region_c;
      s1_frac   <= frac_c;
      s1_s      <= HSV[23:16];
      s1_v      <= HSV[15:8];
      s1_szero  <= (HSV[23:16] == 8'd0);

      s2_valid  <= s1_valid;
      s2_region <= s1_region;
      s2_v      <= s1_v;
      s2_szero  <= s1_szero;
      s2_p      <= scale(s1_v, 8'd255 - s1_s);
      s2_sf     <= scale(s1_s, s1_frac);
      s2_sg     <= scale(s1_s, 8'd255 - s1_frac);

      out_valid <= s2_valid;
      // RGB only updates on valid slots, so it stays 0 after reset until
      // the first real sample and otherwise shows the last valid result.
      if (s2_valid) begin
        RGB <= {b_c, g_c, r_c, 8'h00};
      end
    end
  end

endmodule

// File: tb/tb_hsv2rgb.sv
module tb_hsv2rgb;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic        in_valid;
  logic [31:0] HSV;
  logic        out_valid;
  logic [31:0] RGB;

  hsv2rgb #(.LATENCY(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .in_valid  (in_valid),
    .HSV       (HSV),
    .out_valid (out_valid),
    .RGB       (RGB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hsv;
    logic [31:0] rgb;
    string       name;
  } vec_t;

  int tests = 0;
  int fails = 0;

  vec_t        tbl[$];
  vec_t        sbq[$];
  logic [31:0] drv_exp;
  string       drv_name;

  logic [2:0]  vsh;
  logic [31:0] exp_rgb;
  string       exp_name;
  bit          seen;

  // Independent reference: plain integer divide/modulo, no ladder.
  function automatic logic [31:0] ref_rgb(input logic [31:0] w);
    int h, s, v, region, rem, frac, p, q, t, sf, sg, r, g, b;
    h = int'(w[31:24]);
    s = int'(w[23:16]);
    v = int'(w[15:8]);
    if (h >= 180) h = h - 180;
    region = h / 30;
    rem    = h % 30;
    frac   = (rem * 17) / 2;
    p  = (v * (255 - s)) / 256;
    sf = (s * frac) / 256;
    sg = (s * (255 - frac)) / 256;
    q  = (v * (255 - sf)) / 256;
    t  = (v * (255 - sg)) / 256;
    case (region)
      0:       begin r = v; g = t; b = p; end
      1:       begin r = q; g = v; b = p; end
      2:       begin r = p; g = v; b = t; end
      3:       begin r = p; g = q; b = v; end
      4:       begin r = t; g = p; b = v; end
      default: begin r = v; g = p; b = q; end
    endcase
    if (s == 0) begin
      r = v; g = v; b = v;
    end
    return {8'(b), 8'(g), 8'(r), 8'h00};
  endfunction

  // Monitor / scoreboard: expectations are pushed when the pipeline
  // accepts a sample and popped when the bench's valid shadow says the
  // result is due.
  always @(posedge clk) begin
    vec_t cur;
    if (rst) begin
      vsh      = 3'b000;
      sbq.delete();
      exp_rgb  = 32'h0;
      exp_name = "reset";
      seen     = 1'b0;
    end else if (clk_en) begin
      if (in_valid) sbq.push_back('{hsv: HSV, rgb: drv_exp, name: drv_name});
      vsh = {vsh[1:0], in_valid};
      if (vsh[2]) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard_empty at %0t: result due but none queued", $time);
        end else begin
          cur      = sbq.pop_front();
          exp_rgb  = cur.rgb;
          exp_name = cur.name;
          seen     = 1'b1;
        end
      end
    end
    #1;
    tests++;
    if (out_valid !== vsh[2]) begin
      fails++;
      $display("FAIL out_valid at %0t: got %b want %b", $time, out_valid, vsh[2]);
    end
    if (vsh[2] || !seen) begin
      tests++;
      if (RGB !== exp_rgb) begin
        fails++;
        $display("FAIL rgb_%s at %0t: got %08h want %08h", exp_name, $time, RGB, exp_rgb);
      end
    end
  end

  task automatic step(input logic r, input logic en, input logic v,
                      input logic [31:0] w, input logic [31:0] e, input string nm);
    @(negedge clk);
    rst      = r;
    clk_en   = en;
    in_valid = v;
    HSV      = w;
    drv_exp  = e;
    drv_name = nm;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic        en;
    logic        v;

    tbl.push_back('{hsv: 32'h00FFFF00, rgb: 32'h0000FF00, name: "red"});
    tbl.push_back('{hsv: 32'h3CFFFF00, rgb: 32'h00FF0000, name: "green"});
    tbl.push_back('{hsv: 32'h78FFFF00, rgb: 32'hFF000000, name: "blue"});
    tbl.push_back('{hsv: 32'h57008000, rgb: 32'h80808000, name: "grey"});
    tbl.push_back('{hsv: 32'h0FFFFF00, rgb: 32'h007FFF00, name: "h15"});
    tbl.push_back('{hsv: 32'hB4FFFF00, rgb: 32'h0000FF00, name: "wrap180"});
    tbl.push_back('{hsv: 32'h1EFFFF00, rgb: 32'h00FFFE00, name: "h30"});
    tbl.push_back('{hsv: 32'h5AFFFF00, rgb: 32'hFFFE0000, name: "h90"});
    tbl.push_back('{hsv: 32'h96FFFF00, rgb: 32'hFE00FF00, name: "h150"});
    tbl.push_back('{hsv: 32'hB3FFFF00, rgb: 32'h0900FF00, name: "h179"});
    tbl.push_back('{hsv: 32'h2D00FF00, rgb: 32'hFFFFFF00, name: "white"});
    tbl.push_back('{hsv: 32'h20FF0000, rgb: 32'h00000000, name: "black"});
    tbl.push_back('{hsv: 32'h0080C800, rgb: 32'h6364C800, name: "halfsat"});
    tbl.push_back('{hsv: 32'h00FFFFAB, rgb: 32'h0000FF00, name: "lowbyte"});
    tbl.push_back('{hsv: 32'hFFFFFF00, rgb: 32'h7FFF0000, name: "wrap255"});

    rst      = 1'b1;
    clk_en   = 1'b1;
    in_valid = 1'b1;
    HSV      = 32'hFFFFFF00;
    drv_exp  = 32'h0;
    drv_name = "rst";
    repeat (2) @(negedge clk);

    // Release reset, keep driving the all-ones word but with no valid.
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'hFFFFFF00, 32'h0, "idle");

    // Isolated samples.
    foreach (tbl[i]) begin
      step(1'b0, 1'b1, 1'b1, tbl[i].hsv, tbl[i].rgb, tbl[i].name);
      repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, "idle");
    end

    // Back-to-back stream.
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 1'b1, tbl[i].hsv, tbl[i].rgb, tbl[i].name);
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, "idle");

    // Stream with a 4-cycle stall in the middle; junk presented while stalled.
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b1, 1'b1, tbl[i].hsv, tbl[i].rgb, tbl[i].name);
    repeat (4) step(1'b0, 1'b0, 1'b1, 32'h3C808000, 32'h0, "stalljunk");
    for (int i = 6; i < tbl.size(); i++)
      step(1'b0, 1'b1, 1'b1, tbl[i].hsv, tbl[i].rgb, tbl[i].name);
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, "idle");

    // Random samples with random enable and valid gaps.
    for (int i = 0; i < 80; i++) begin
      w  = $urandom;
      en = ($urandom_range(0, 3) != 0);
      v  = 1'($urandom_range(0, 1));
      step(1'b0, en, v, w, ref_rgb(w), "rand");
    end
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, "idle");

    // Reset with samples in flight: nothing stale may emerge.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b1, tbl[i].hsv, tbl[i].rgb, tbl[i].name);
    step(1'b1, 1'b0, 1'b1, 32'h78FFFF00, 32'h0, "rstjunk");
    repeat (5) step(1'b0, 1'b1, 1'b0, 32'hFFFFFF00, 32'h0, "idle");
    step(1'b0, 1'b1, 1'b1, tbl[2].hsv, tbl[2].rgb, "blue_after_rst");
    repeat (5) step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, "idle");

    @(posedge clk);
    #2;
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending results want 0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
